// File: rtl/bgpu_pkg.sv
// Shared GPU pipeline types and default configuration used by the dispatch
// arbiter, the operand collector and the execution units.
package bgpu_pkg;

    localparam int CfgNumWarps        = 8;
    localparam int CfgNumTags         = 8;
    localparam int CfgPcWidth         = 32;
    localparam int CfgWarpWidth       = 32;
    localparam int CfgRegIdxWidth     = 6;
    localparam int CfgOperandsPerInst = 2;
    localparam int CfgWidWidth        = (CfgNumWarps > 1) ? $clog2(CfgNumWarps) : 1;

    // Warp identifier carried alongside every instruction leaving dispatch.
    typedef logic [CfgWidWidth-1:0] warp_id_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [1:0] fmt;
        logic [7:0] imm;
    } inst_t;

    // Adds an offset to a ring position, assuming both already lie in [0, n).
    function automatic int unsigned rr_mod_add(input int unsigned base,
                                               input int unsigned off,
                                               input int unsigned n);
        int unsigned sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dispatch_arbiter_rr_select.sv
// Combinational round-robin picker: returns the first set request at or after
// the pointer position, wrapping around the request vector.
module dispatch_arbiter_rr_select
    import bgpu_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned cand;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = rr_mod_add(32'(ptr_i), off, N);
            if (!valid_o && req_i[IdxW'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(cand);
            end
        end
        if (valid_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/dispatch_arbiter.sv
// Round-robin arbiter sharing one operand collector between per-warp
// dispatchers, with a single-entry output register tagged by warp ID.
module dispatch_arbiter
    import bgpu_pkg::*;
#(
    parameter  int NumWarps        = CfgNumWarps,
    parameter  int NumTags         = CfgNumTags,
    parameter  int PcWidth         = CfgPcWidth,
    parameter  int WarpWidth       = CfgWarpWidth,
    parameter  int RegIdxWidth     = CfgRegIdxWidth,
    parameter  int OperandsPerInst = CfgOperandsPerInst,
    localparam int TagWidth        = (NumTags > 1) ? $clog2(NumTags) : 1,
    localparam int WidWidth        = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                                                     clk_i,
    input  logic                                                     rst_i,

    input  logic [NumWarps-1:0]                                      disp_valid_i,
    output logic [NumWarps-1:0]                                      disp_ready_o,
    input  logic [NumWarps-1:0][TagWidth-1:0]                        disp_tag_i,
    input  logic [NumWarps-1:0][PcWidth-1:0]                         disp_pc_i,
    input  logic [NumWarps-1:0][WarpWidth-1:0]                       disp_act_mask_i,
    input  inst_t [NumWarps-1:0]                                     disp_inst_i,
    input  logic [NumWarps-1:0][RegIdxWidth-1:0]                     disp_dst_i,
    input  logic [NumWarps-1:0][OperandsPerInst-1:0]                 disp_operands_required_i,
    input  logic [NumWarps-1:0][OperandsPerInst-1:0][RegIdxWidth-1:0] disp_operands_i,

    input  logic                                                     opc_ready_i,
    output logic                                                     opc_valid_o,
    output logic [WidWidth-1:0]                                      opc_warp_id_o,
    output logic [TagWidth-1:0]                                      opc_tag_o,
    output logic [PcWidth-1:0]                                       opc_pc_o,
    output logic [WarpWidth-1:0]                                     opc_act_mask_o,
    output inst_t                                                    opc_inst_o,
    output logic [RegIdxWidth-1:0]                                   opc_dst_o,
    output logic [OperandsPerInst-1:0]                               opc_operands_required_o,
    output logic [OperandsPerInst-1:0][RegIdxWidth-1:0]              opc_operands_o
);

    logic                                          load;
    logic [NumWarps-1:0]                           sel_grant;
    logic [WidWidth-1:0]                           sel_idx;
    logic                                          sel_valid;

    logic                                          valid_q, valid_d;
    logic [WidWidth-1:0]                           ptr_q, ptr_d;
    logic [WidWidth-1:0]                           wid_q, wid_d;
    logic [TagWidth-1:0]                           tag_q, tag_d;
    logic [PcWidth-1:0]                            pc_q, pc_d;
    logic [WarpWidth-1:0]                          mask_q, mask_d;
    inst_t                                         inst_q, inst_d;
    logic [RegIdxWidth-1:0]                        dst_q, dst_d;
    logic [OperandsPerInst-1:0]                    opreq_q, opreq_d;
    logic [OperandsPerInst-1:0][RegIdxWidth-1:0]   ops_q, ops_d;

    dispatch_arbiter_rr_select #(
        .N (NumWarps)
    ) u_rr_select (
        .req_i   (disp_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (sel_grant),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // The output slot can take a new entry whenever it is empty or is being
    // drained this cycle, so a new winner replaces the old one without a bubble.
    always_comb begin
        load         = !valid_q || opc_ready_i;
        disp_ready_o = (load && !rst_i) ? sel_grant : '0;

        valid_d = valid_q;
        ptr_d   = ptr_q;
        wid_d   = wid_q;
        tag_d   = tag_q;
        pc_d    = pc_q;
        mask_d  = mask_q;
        inst_d  = inst_q;
        dst_d   = dst_q;
        opreq_d = opreq_q;
        ops_d   = ops_q;

        if (load) begin
            valid_d = sel_valid;
            if (sel_valid) begin
                ptr_d   = WidWidth'(rr_mod_add(32'(sel_idx), 1, NumWarps));
                wid_d   = sel_idx;
                tag_d   = disp_tag_i[sel_idx];
                pc_d    = disp_pc_i[sel_idx];
                mask_d  = disp_act_mask_i[sel_idx];
                inst_d  = disp_inst_i[sel_idx];
                dst_d   = disp_dst_i[sel_idx];
                opreq_d = disp_operands_required_i[sel_idx];
                ops_d   = disp_operands_i[sel_idx];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ptr_q   <= '0;
            wid_q   <= '0;
            tag_q   <= '0;
            pc_q    <= '0;
            mask_q  <= '0;
            inst_q  <= '0;
            dst_q   <= '0;
            opreq_q <= '0;
            ops_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            wid_q   <= wid_d;
            tag_q   <= tag_d;
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            inst_q  <= inst_d;
            dst_q   <= dst_d;
            opreq_q <= opreq_d;
            ops_q   <= ops_d;
        end
    end

    assign opc_valid_o             = valid_q;
    assign opc_warp_id_o           = wid_q;
    assign opc_tag_o               = tag_q;
    assign opc_pc_o                = pc_q;
    assign opc_act_mask_o          = mask_q;
    assign opc_inst_o              = inst_q;
    assign opc_dst_o               = dst_q;
    assign opc_operands_required_o = opreq_q;
    assign opc_operands_o          = ops_q;

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(disp_ready_o));

    a_ready_implies_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        (disp_ready_o & ~disp_valid_i) == '0);

    a_output_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (opc_valid_o && !opc_ready_i) |=>
            (opc_valid_o && $stable(opc_warp_id_o) && $stable(opc_tag_o) &&
             $stable(opc_pc_o) && $stable(opc_act_mask_o) && $stable(opc_inst_o) &&
             $stable(opc_dst_o) && $stable(opc_operands_required_o) &&
             $stable(opc_operands_o)));

    // Requesters must keep valid and payload steady until they see ready.
    for (genvar w = 0; w < NumWarps; w++) begin : g_req_stable
        a_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
            (disp_valid_i[w] && !disp_ready_o[w]) |=>
                (disp_valid_i[w] && $stable(disp_tag_i[w]) && $stable(disp_pc_i[w]) &&
                 $stable(disp_act_mask_i[w]) && $stable(disp_inst_i[w]) &&
                 $stable(disp_dst_i[w]) && $stable(disp_operands_required_i[w]) &&
                 $stable(disp_operands_i[w])));
    end
`endif

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Randomised scoreboard bench for dispatch_arbiter with directed scenarios
// for reset, rotation, stall, wrap-around and single-requester streaming.
module tb_dispatch_arbiter;
    import bgpu_pkg::*;

    localparam int NW    = CfgNumWarps;
    localparam int TW    = (CfgNumTags > 1) ? $clog2(CfgNumTags) : 1;
    localparam int PW    = CfgPcWidth;
    localparam int MW    = CfgWarpWidth;
    localparam int RW    = CfgRegIdxWidth;
    localparam int OPI   = CfgOperandsPerInst;
    localparam int WW    = (NW > 1) ? $clog2(NW) : 1;
    localparam int InstW = $bits(inst_t);
    localparam int OpsW  = OPI * RW;

    typedef struct packed {
        logic [TW-1:0]          tag;
        logic [PW-1:0]          pc;
        logic [MW-1:0]          mask;
        inst_t                  inst;
        logic [RW-1:0]          dst;
        logic [OPI-1:0]         req;
        logic [OPI-1:0][RW-1:0] ops;
    } pl_t;

    logic                          clk;
    logic                          rst;
    logic [NW-1:0]                 dv;
    logic [NW-1:0]                 dready;
    logic [NW-1:0][TW-1:0]         tag_v;
    logic [NW-1:0][PW-1:0]         pc_v;
    logic [NW-1:0][MW-1:0]         mask_v;
    inst_t [NW-1:0]                inst_v;
    logic [NW-1:0][RW-1:0]         dst_v;
    logic [NW-1:0][OPI-1:0]        req_v;
    logic [NW-1:0][OPI-1:0][RW-1:0] ops_v;
    logic                          ordy;
    logic                          opc_valid;
    logic [WW-1:0]                 opc_wid;
    logic [TW-1:0]                 opc_tag;
    logic [PW-1:0]                 opc_pc;
    logic [MW-1:0]                 opc_mask;
    inst_t                         opc_inst;
    logic [RW-1:0]                 opc_dst;
    logic [OPI-1:0]                opc_req;
    logic [OPI-1:0][RW-1:0]        opc_ops;

    int      checks;
    int      errors;
    pl_t     exp_q [NW][$];
    pl_t     last_pl [NW];
    int      grant_log [$];
    logic [NW-1:0] hs_mask;

    // Reference model state: output slot contents and round-robin start point.
    bit      m_valid;
    int      m_warp;
    int      m_ptr;

    dispatch_arbiter dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .disp_valid_i             (dv),
        .disp_ready_o             (dready),
        .disp_tag_i               (tag_v),
        .disp_pc_i                (pc_v),
        .disp_act_mask_i          (mask_v),
        .disp_inst_i              (inst_v),
        .disp_dst_i               (dst_v),
        .disp_operands_required_i (req_v),
        .disp_operands_i          (ops_v),
        .opc_ready_i              (ordy),
        .opc_valid_o              (opc_valid),
        .opc_warp_id_o            (opc_wid),
        .opc_tag_o                (opc_tag),
        .opc_pc_o                 (opc_pc),
        .opc_act_mask_o           (opc_mask),
        .opc_inst_o               (opc_inst),
        .opc_dst_o                (opc_dst),
        .opc_operands_required_o  (opc_req),
        .opc_operands_o           (opc_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkLog(input string name, input int expv[$]);
        checkOutput($sformatf("%s_len", name), 128'(grant_log.size()), 128'(expv.size()));
        for (int i = 0; i < expv.size(); i++) begin
            if (i < grant_log.size()) begin
                checkOutput($sformatf("%s[%0d]", name, i), 128'(grant_log[i]), 128'(expv[i]));
            end
        end
    endtask

    task automatic applyStimulus(input int w);
        pl_t p;
        p.tag  = TW'($urandom);
        p.pc   = PW'($urandom);
        p.mask = MW'($urandom);
        p.inst = inst_t'(InstW'($urandom));
        p.dst  = RW'($urandom);
        p.req  = OPI'($urandom);
        p.ops  = OpsW'($urandom);
        tag_v[w]  = p.tag;
        pc_v[w]   = p.pc;
        mask_v[w] = p.mask;
        inst_v[w] = p.inst;
        dst_v[w]  = p.dst;
        req_v[w]  = p.req;
        ops_v[w]  = p.ops;
        dv[w]     = 1'b1;
        exp_q[w].push_back(p);
        last_pl[w] = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dv = dv & ~hs_mask;
    endtask

    task automatic drain();
        ordy = 1'b1;
        for (int i = 0; i < 50 && (dv != '0 || opc_valid); i++) begin
            tick();
        end
        checkOutput("drain_idle", 128'({dv, opc_valid}), 128'(0));
    endtask

    task automatic flushBench();
        dv      = '0;
        hs_mask = '0;
        for (int w = 0; w < NW; w++) begin
            exp_q[w].delete();
        end
    endtask

    // Monitor: predicts grants from the arbitration rules and checks every
    // presented output against the per-warp expected queues.
    always @(negedge clk) begin
        bit            ld;
        bit            found;
        int            win;
        int            c;
        logic [NW-1:0] er;
        pl_t           act;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            m_warp  = 0;
            hs_mask = '0;
            checkOutput("rst_ready", 128'(dready), 128'(0));
        end else begin
            ld    = !m_valid || ordy;
            found = 1'b0;
            win   = 0;
            for (int k = 0; k < NW; k++) begin
                c = (m_ptr + k) % NW;
                if (!found && dv[c]) begin
                    found = 1'b1;
                    win   = c;
                end
            end
            er = '0;
            if (ld && found) er[win] = 1'b1;
            checkOutput("disp_ready", 128'(dready), 128'(er));
            checkOutput("opc_valid", 128'(opc_valid), 128'(m_valid));
            if (m_valid) begin
                checkOutput("opc_warp_id", 128'(opc_wid), 128'(m_warp));
                checkOutput("sb_nonempty", 128'(exp_q[m_warp].size() != 0), 128'(1));
                if (exp_q[m_warp].size() != 0) begin
                    act.tag  = opc_tag;
                    act.pc   = opc_pc;
                    act.mask = opc_mask;
                    act.inst = opc_inst;
                    act.dst  = opc_dst;
                    act.req  = opc_req;
                    act.ops  = opc_ops;
                    checkOutput("opc_payload", 128'(act), 128'(exp_q[m_warp][0]));
                    if (ordy) void'(exp_q[m_warp].pop_front());
                end
            end
            for (int k = 0; k < NW; k++) begin
                if (dready[k]) grant_log.push_back(k);
            end
            hs_mask = dv & dready;
            if (ld) begin
                if (found) begin
                    m_valid = 1'b1;
                    m_warp  = win;
                    m_ptr   = (win + 1) % NW;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e[$];
        int left;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        ordy   = 1'b0;
        tag_v  = '0;
        pc_v   = '0;
        mask_v = '0;
        inst_v = '0;
        dst_v  = '0;
        req_v  = '0;
        ops_v  = '0;
        flushBench();

        @(negedge clk);
        #1;
        checkOutput("reset_opc_valid", 128'(opc_valid), 128'(0));
        checkOutput("reset_opc_pc", 128'(opc_pc), 128'(0));
        checkOutput("reset_opc_warp_id", 128'(opc_wid), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] rotation with all warps requesting");
        ordy = 1'b1;
        grant_log.delete();
        for (int cyc = 0; cyc < 9; cyc++) begin
            for (int w = 0; w < NW; w++) begin
                if (!dv[w]) applyStimulus(w);
            end
            tick();
        end
        e.delete();
        for (int i = 0; i < 9; i++) e.push_back(i % NW);
        checkLog("rotation", e);
        drain();

        $display("[TB] stall with warps 1 and 5 requesting");
        grant_log.delete();
        applyStimulus(1);
        applyStimulus(5);
        tick();
        for (int i = 0; i < 4; i++) begin
            ordy = 1'b0;
            #1;
            checkOutput("stall_ready", 128'(dready), 128'(0));
            checkOutput("stall_warp_id", 128'(opc_wid), 128'(1));
            checkOutput("stall_pc", 128'(opc_pc), 128'(last_pl[1].pc));
            tick();
        end
        ordy = 1'b1;
        #1;
        checkOutput("release_ready", 128'(dready), 128'(NW'(1) << 5));
        tick();
        checkOutput("release_warp_id", 128'(opc_wid), 128'(5));
        drain();

        $display("[TB] wrap-around from pointer 6 with warps 2 and 7");
        grant_log.delete();
        applyStimulus(2);
        applyStimulus(7);
        tick();
        tick();
        drain();
        e.delete();
        e.push_back(7);
        e.push_back(2);
        checkLog("wrap", e);

        $display("[TB] single requester streaming on warp 3");
        grant_log.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3);
            tick();
        end
        e.delete();
        for (int i = 0; i < 5; i++) e.push_back(3);
        checkLog("single", e);
        drain();

        $display("[TB] reset while warp 2 is held");
        ordy = 1'b0;
        applyStimulus(2);
        tick();
        applyStimulus(4);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_opc_valid", 128'(opc_valid), 128'(0));
        checkOutput("midrst_ready", 128'(dready), 128'(0));
        checkOutput("midrst_opc_pc", 128'(opc_pc), 128'(0));
        checkOutput("midrst_opc_tag", 128'(opc_tag), 128'(0));
        flushBench();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        grant_log.delete();
        ordy = 1'b1;
        applyStimulus(1);
        applyStimulus(5);
        tick();
        tick();
        drain();
        e.delete();
        e.push_back(1);
        e.push_back(5);
        checkLog("post_reset", e);

        $display("[TB] random soak");
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int w = 0; w < NW; w++) begin
                if (!dv[w] && $urandom_range(0, 99) < 40) applyStimulus(w);
            end
            ordy = 1'($urandom_range(0, 1));
            tick();
        end
        drain();
        left = 0;
        for (int w = 0; w < NW; w++) left += exp_q[w].size();
        checkOutput("sb_leftover", 128'(left), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
